// File: rtl/transpose_tile_ctrl.sv
// Tile sequencer for the circulant transpose buffer: fill, transposed drain, column stream.
// Optional perf counters are built when TRANSPOSE_TILE_CTRL_PERF_EN is defined.
module transpose_tile_ctrl #(
  parameter int MATRIX_DIM = 4,
  parameter int MEM_WIDTH  = 8,
  parameter int ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
  parameter int ADDR_LEN   = $clog2(MATRIX_DIM),
  parameter int READ_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROW_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 tile_done,
  output logic                 buf_wen,
  output logic [ADDR_LEN-1:0]  buf_waddr,
  output logic [ROW_WIDTH-1:0] buf_wdata,
  output logic                 buf_ren,
  output logic [ADDR_LEN-1:0]  buf_raddr,
  input  logic [ROW_WIDTH-1:0] buf_rdata
`ifdef TRANSPOSE_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_tiles,
  output logic [31:0]          perf_stall
`endif
);

  localparam int IFW = $clog2(READ_LAT + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = ((IFW > CW) ? IFW : CW) + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(MATRIX_DIM - 1);

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    FLUSH
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_LEN-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_LEN-1:0] rd_cnt_q, rd_cnt_d;
  logic [READ_LAT-1:0] tag_v_q, tag_v_d;
  logic [READ_LAT-1:0] tag_l_q, tag_l_d;
  logic                done_q, done_d;
  logic                rd_last;

  logic [ROW_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                 fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;

  logic [IFW-1:0] inflight;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           head_last;
  logic           credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + IFW'(tag_v_q[i]);
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign push       = tag_v_q[READ_LAT-1];
  assign pop        = !fifo_empty && out_ready;
  assign head_last  = !fifo_empty && fifo_last_q[rd_ptr_q];

  // A pop this cycle already frees its slot for a new read.
  assign credit = (SW'(inflight) + SW'(cnt_q) - SW'(pop)) < SW'(FIFO_DEPTH);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign out_last  = head_last;
  assign tile_done = done_q;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    done_d    = 1'b0;
    rd_last   = 1'b0;
    in_ready  = 1'b0;
    buf_wen   = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_ren   = 1'b0;
    buf_raddr = '0;
    unique case (state_q)
      FILL: begin
        in_ready  = 1'b1;
        buf_wen   = in_valid;
        buf_wdata = in_data;
        if (in_valid) begin
          buf_waddr = wr_cnt_q;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_LEN'(1);
          end
        end
      end
      DRAIN: begin
        if (credit) begin
          buf_ren   = 1'b1;
          buf_raddr = rd_cnt_q;
          rd_last   = (rd_cnt_q == LAST_IDX);
          if (rd_last) begin
            rd_cnt_d = '0;
            state_d  = FLUSH;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_LEN'(1);
          end
        end
      end
      FLUSH: begin
        if (pop && head_last && (inflight == '0)) begin
          state_d = FILL;
          done_d  = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    tag_v_d    = '0;
    tag_l_d    = '0;
    tag_v_d[0] = buf_ren;
    tag_l_d[0] = buf_ren && rd_last;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      tag_v_q  <= '0;
      tag_l_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      tag_v_q  <= tag_v_d;
      tag_l_q  <= tag_l_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= buf_rdata;
        fifo_last_q[wr_ptr_q] <= tag_l_q[READ_LAT-1];
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

`ifdef TRANSPOSE_TILE_CTRL_PERF_EN
  logic [31:0] perf_tiles_q;
  logic [31:0] perf_stall_q;
  logic        stall;

  assign stall = (state_q == DRAIN) && !credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_tiles_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (done_q && !(&perf_tiles_q)) begin
        perf_tiles_q <= perf_tiles_q + 32'd1;
      end
      if (stall && !(&perf_stall_q)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_tiles = perf_tiles_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_transpose_tile_ctrl.sv
// Bench for transpose_tile_ctrl: buffer model plus a row/column reference queue.
// Directed steps with randomized data and consumer back-pressure.
module tb_transpose_tile_ctrl;

  localparam int M  = 4;
  localparam int W  = 8;
  localparam int RW = M * W;
  localparam int AL = 2;
  localparam int RL = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          tile_done;
  logic          buf_wen;
  logic [AL-1:0] buf_waddr;
  logic [RW-1:0] buf_wdata;
  logic          buf_ren;
  logic [AL-1:0] buf_raddr;
  logic [RW-1:0] buf_rdata;
`ifdef TRANSPOSE_TILE_CTRL_PERF_EN
  logic [31:0]   perf_tiles;
  logic [31:0]   perf_stall;
`endif

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int nren = 0;
  int nov = 0;
  int ndone = 0;
  int first_ren = -1;
  int first_ov = -1;
  int rdy_mode = 0;
  bit busy = 1'b0;
  bit last_prev = 1'b0;
  bit acc_seen = 1'b0;

  logic [RW-1:0] tile_buf [M];
  logic [RW-1:0] t1c [M];
  logic [RW-1:0] rows [$];
  logic [RW:0]   exp_q [$];
  logic [RW-1:0] seen [$];
  int            waddrs [$];

  always #5 clk = ~clk;

  transpose_tile_ctrl #(
    .MATRIX_DIM(M),
    .MEM_WIDTH (W),
    .ROW_WIDTH (RW),
    .ADDR_LEN  (AL),
    .READ_LAT  (RL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .tile_done(tile_done),
    .buf_wen  (buf_wen),
    .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata),
    .buf_ren  (buf_ren),
    .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata)
`ifdef TRANSPOSE_TILE_CTRL_PERF_EN
    ,
    .perf_tiles(perf_tiles),
    .perf_stall(perf_stall)
`endif
  );

  // Transpose buffer: row writes, column reads after RL cycles.
  logic [RW-1:0] bmem  [M];
  logic [RW-1:0] bpipe [RL];

  function automatic logic [RW-1:0] bcol(input int c);
    logic [RW-1:0] r;
    logic [RW-1:0] rk;
    r = '0;
    for (int k = 0; k < M; k++) begin
      rk = bmem[k];
      r[k*W +: W] = rk[c*W +: W];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (buf_wen) bmem[buf_waddr] <= buf_wdata;
    bpipe[0] <= buf_ren ? bcol(int'(buf_raddr)) : RW'($urandom);
    for (int i = 1; i < RL; i++) bpipe[i] <= bpipe[i-1];
  end

  assign buf_rdata = bpipe[RL-1];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [RW-1:0] obs,
                      input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample and check at negedge, then advance past posedge.
  task automatic cyc();
    bit            acc;
    bit            hs;
    logic [RW:0]   e;
    logic [RW-1:0] col;
    logic [RW-1:0] rk;
    @(negedge clk);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    hs  = (out_valid === 1'b1) && (out_ready === 1'b1);
    chk1("in_ready", in_ready, !busy);
    chk1("tile_done", tile_done, last_prev);
    chk1("buf_wen", buf_wen, acc);
    chkv("buf_waddr", RW'(buf_waddr), acc ? RW'(rows.size()) : '0);
    if (acc) chkv("buf_wdata", buf_wdata, in_data);
    if (buf_ren !== 1'b1) chkv("buf_raddr_idle", RW'(buf_raddr), '0);
    if (buf_ren === 1'b1) begin
      nren++;
      if (first_ren < 0) first_ren = cyc_n;
    end
    if (out_valid === 1'b1) begin
      nov++;
      if (first_ov < 0) first_ov = cyc_n;
    end
    if (tile_done === 1'b1) ndone++;
    if (buf_wen === 1'b1) waddrs.push_back(int'(buf_waddr));
    last_prev = 1'b0;
    if (hs) begin
      chk1("col_avail", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chkv("out_data", out_data, e[RW-1:0]);
        chk1("out_last", out_last, e[RW]);
        seen.push_back(out_data);
        if (e[RW]) begin
          last_prev = 1'b1;
          busy = 1'b0;
        end
      end
    end
    acc_seen = acc;
    if (acc) begin
      rows.push_back(in_data);
      if (rows.size() == M) begin
        for (int c = 0; c < M; c++) begin
          for (int k = 0; k < M; k++) begin
            rk = rows[k];
            col[k*W +: W] = rk[c*W +: W];
          end
          exp_q.push_back({c == M - 1, col});
        end
        rows.delete();
        busy = 1'b1;
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = ~out_ready;
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_tile_done", tile_done, 1'b0);
    chk1("rst_buf_wen", buf_wen, 1'b0);
    chk1("rst_buf_ren", buf_ren, 1'b0);
    chkv("rst_out_data", out_data, '0);
    rst = 1'b0;
    rows.delete();
    exp_q.delete();
    seen.delete();
    waddrs.delete();
    busy = 1'b0;
    last_prev = 1'b0;
    nren = 0;
    nov = 0;
    ndone = 0;
    first_ren = -1;
    first_ov = -1;
  endtask

  task automatic rand_tile();
    for (int i = 0; i < M; i++) tile_buf[i] = RW'($urandom);
  endtask

  task automatic send_tile(input int gap, input bit hold);
    int t;
    for (int i = 0; i < M; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        cyc();
      end
      in_valid = 1'b1;
      in_data = tile_buf[i];
      t = 0;
      acc_seen = 1'b0;
      while (!acc_seen && t < 100) begin
        cyc();
        t++;
      end
      chk1("row_accept", acc_seen, 1'b1);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int d0;
    int t;
    d0 = ndone;
    t = 0;
    while (ndone == d0 && t < budget) begin
      cyc();
      t++;
    end
    chk1("done_seen", ndone != d0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Directed tile: element c of row r is {r,c}.
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) tile_buf[r][c*W +: W] = W'(r * 16 + c);
    end
    t1c[0] = 32'h30201000;
    t1c[1] = 32'h31211101;
    t1c[2] = 32'h32221202;
    t1c[3] = 32'h33231303;
    out_ready = 1'b1;
    send_tile(0, 1'b0);
    run_to_done(60);
    idle(3);
    chki("t1_ncols", seen.size(), M);
    if (seen.size() == M) begin
      for (int i = 0; i < M; i++) chkv("t1_col", seen[i], t1c[i]);
    end
    chki("t1_latency", first_ov - first_ren, RL + 1);
    chki("t1_done_once", ndone, 1);

    // Back-to-back tiles with in_valid held high.
    ndone = 0;
    rand_tile();
    send_tile(0, 1'b1);
    rand_tile();
    send_tile(0, 1'b0);
    run_to_done(80);
    chki("t2_done_count", ndone, 2);
    chki("t2_exp_left", exp_q.size(), 0);

    // Consumer stalled for the whole drain.
    do_reset();
    rand_tile();
    out_ready = 1'b0;
    send_tile(0, 1'b0);
    idle(20);
    chki("t3_reads", nren, FD);
    chk1("t3_fifo_valid", out_valid, 1'b1);
    chki("t3_no_cols", seen.size(), 0);
    out_ready = 1'b1;
    run_to_done(40);
    chki("t3_cols", seen.size(), M);

    // Toggling consumer ready.
    do_reset();
    rand_tile();
    out_ready = 1'b1;
    rdy_mode = 2;
    send_tile(0, 1'b0);
    run_to_done(80);
    rdy_mode = 0;
    out_ready = 1'b1;
    chki("t4_cols", seen.size(), M);
`ifdef TRANSPOSE_TILE_CTRL_PERF_EN
    chkv("t4_perf_tiles", perf_tiles, 32'd1);
    chkv("t4_perf_stall", perf_stall, 32'd0);
`endif

    // Reset in the middle of the drain.
    do_reset();
    rand_tile();
    send_tile(0, 1'b0);
    for (int t = 0; t < 20 && nren == 0; t++) cyc();
    chki("t5_ren_seen", int'(nren != 0), 1);
    cyc();
    do_reset();
    idle(15);
    chki("t5_no_stale", nov, 0);
    rand_tile();
    send_tile(0, 1'b0);
    run_to_done(60);
    chki("t5_fresh_cols", seen.size(), M);

    // Gapped rows: one row every 3 cycles.
    do_reset();
    rand_tile();
    send_tile(2, 1'b0);
    chki("t6_nwrites", waddrs.size(), M);
    if (waddrs.size() == M) begin
      for (int i = 0; i < M; i++) chki("t6_waddr", waddrs[i], i);
    end
    run_to_done(60);

    // Random gaps and random back-pressure across several tiles.
    rdy_mode = 1;
    for (int n = 0; n < 6; n++) begin
      rand_tile();
      send_tile($urandom_range(0, 2), 1'b0);
      run_to_done(200);
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    idle(4);
    chki("t7_exp_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
